fir_tdm_scheduler: RTL and testbench
====================================

Name: fir_tdm_scheduler

Overview:
Sequences multi-channel PCM frames from the I2S receiver into one shared, channel-multiplexed FIR interpolator, then reassembles the FIR output into a parallel frame for the I2S transmitter. It arbitrates the single FIR between channels in fixed time slots, tags each slot with sop/eop, applies FIR back-pressure, and detects overruns and output framing errors. Sits between i2s_rx_asrc and i2s_tx_asrc in the audio upsampler path.

Parameters:
NUM_CH, 2, channels per frame (>=2); slot 0 is left and is issued first.
IN_W, 16, input sample width.
OUT_W, 24, FIR output sample width, signed.
GAP_CYCLES, 1, idle cycles inserted after each issued frame (0..15).

Ports:
AMCLK_i  in  1  audio master clock; the only clock.
nARST  in  1  asynchronous active-low reset.
in_data_i  in  NUM_CH*IN_W  input frame; channel k at bits [k*IN_W +: IN_W].
in_valid_i  in  1  frame-valid strobe from the receiver.
in_ready_o  out  1  scheduler can accept a frame.
fir_sink_data_o  out  IN_W  sample to FIR.
fir_sink_valid_o  out  1  FIR sink valid.
fir_sink_sop_o  out  1  first slot of frame.
fir_sink_eop_o  out  1  last slot of frame.
fir_sink_ready_i  in  1  FIR sink ready (ready latency 0).
fir_src_data_i  in  OUT_W  FIR result.
fir_src_valid_i  in  1  FIR result valid.
fir_src_sop_i  in  1  FIR result is slot 0.
fir_src_eop_i  in  1  FIR result is last slot.
out_data_o  out  NUM_CH*OUT_W  reassembled frame; same slot layout as input.
out_valid_o  out  1  one-cycle strobe; new frame on out_data_o.
clr_status_i  in  1  synchronous clear of sticky flags.
overrun_o  out  1  sticky: frame offered while in_ready_o=0.
framing_err_o  out  1  sticky: malformed sop/eop sequence from FIR.

Behaviour:
- Reset (async, nARST=0): all outputs 0, except in_ready_o=0 during reset and 1 on the first cycle after release. Issue FSM=IDLE, collector count=0, out_data_o=0.
- Issue FSM, states IDLE/ISSUE/GAP:
  - IDLE: in_ready_o=1. On in_valid_i, latch the frame, set slot k=0, and go to ISSUE. in_ready_o=0 in every other state.
  - ISSUE: fir_sink_valid_o=1 with fir_sink_data_o = latched slot k. sop=(k==0), eop=(k==NUM_CH-1).
    - A slot transfers only when valid and fir_sink_ready_i are both high. While ready is low, data, sop, eop and valid hold stable.
    - On transfer of the eop slot: go to GAP if GAP_CYCLES>0, else IDLE. Otherwise k increments.
  - GAP: valid=0 for exactly GAP_CYCLES cycles, then IDLE.
- Best-case issue latency: first slot on the cycle after acceptance. Back-to-back frames at most every NUM_CH+GAP_CYCLES+1 cycles.
- Overrun: in_valid_i=1 while in_ready_o=0 sets overrun_o and drops the offered frame; the frame in flight is unaffected.
- Collector, on each fir_src_valid_i:
  - sop: write slot 0 of the shadow, count=1. Slot 0 + eop with NUM_CH>1 is an error.
  - Non-sop with count>0: write slot[count], count++.
  - Non-sop with count==0 (missing sop): framing_err_o=1, discard sample.
  - eop with count+1==NUM_CH (including current): copy shadow to out_data_o and pulse out_valid_o on the next cycle; count=0.
  - eop at any other count, or count overflow without eop: framing_err_o=1, discard partial frame, count=0.
- out_data_o changes only on commit; it stays stable between out_valid_o pulses.
- clr_status_i clears both sticky flags. A set event in the same cycle wins.
- No arithmetic on samples; data is passed unmodified.

Optional Feature:
FIR_BYPASS_EN: adds input port bypass_i (1 bit).
- When defined and bypass_i=1: the FIR is not driven (fir_sink_valid_o=0). Each accepted frame appears on out_data_o, each slot sign-extended from IN_W to OUT_W and shifted left by OUT_W-IN_W, with out_valid_o 2 cycles after acceptance.
- bypass_i is sampled only in IDLE; changing it mid-frame takes effect at the next frame.
- Undefined: no bypass_i port; the FIR path is always used.

Decomposition:
- Package fir_tdm_pkg: FSM state encoding (IDLE/ISSUE/GAP), slot-index width function clog2(NUM_CH), default widths.
- One sub-module, fir_tdm_collector: reassembly, framing check and commit. The issue FSM stays in the top level.

Test Plan:
- Frame L=0x1234, R=0xABCD, ready always 1, GAP=1 -> sink slots 0x1234 (sop), then 0xABCD (eop) on consecutive cycles; in_ready_o back at 1 after 4 cycles.
- fir_sink_ready_i low for 3 cycles during slot 1 -> 0xABCD and eop held for 3 cycles, single transfer, no duplicate.
- Second in_valid_i 1 cycle after acceptance -> overrun_o=1, only the first frame issued; clr_status_i clears it.
- FIR returns 0x000100 (sop), then 0xFFFF00 (eop) -> out_data_o={0xFFFF00,0x000100}, one-cycle out_valid_o.
- FIR returns eop without sop -> framing_err_o=1, no out_valid_o, out_data_o unchanged; next well-formed frame commits normally.
- nARST asserted mid-ISSUE -> all outputs 0 immediately; after release, in_ready_o=1 and the next frame starts at slot 0 with sop.

Source files
------------

// File: rtl/fir_tdm_pkg.sv
// Shared types and defaults for the TDM FIR scheduler: issue FSM encoding,
// default widths and the slot-index width helper.
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_e;

  localparam int DEF_NUM_CH     = 2;
  localparam int DEF_IN_W       = 16;
  localparam int DEF_OUT_W      = 24;
  localparam int DEF_GAP_CYCLES = 1;
  localparam int GAP_CNT_W      = 4;

  // Slot index width, never narrower than one bit.
  function automatic int slot_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/fir_tdm_collector.sv
// Reassembles channel-multiplexed FIR results into a parallel frame, checks
// the sop/eop framing and commits complete frames (or bypass frames) to the output.
module fir_tdm_collector
  import fir_tdm_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int OUT_W  = DEF_OUT_W
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [OUT_W-1:0]        i_src_data,
  input  logic                    i_src_valid,
  input  logic                    i_src_sop,
  input  logic                    i_src_eop,
  input  logic                    i_byp_valid,
  input  logic [NUM_CH*OUT_W-1:0] i_byp_frame,
  output logic [NUM_CH*OUT_W-1:0] o_out_data,
  output logic                    o_out_valid,
  output logic                    o_ferr
);

  localparam int SW = slot_w(NUM_CH);
  localparam logic [SW-1:0] LAST = SW'(NUM_CH - 1);

  logic [SW-1:0]           r_count;
  logic [OUT_W-1:0]        r_shadow [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] r_out_data;
  logic                    r_out_valid;

  logic                    w_write;
  logic                    w_commit;
  logic                    w_err;
  logic [SW-1:0]           w_idx;
  logic [SW-1:0]           w_count_nxt;
  logic [NUM_CH*OUT_W-1:0] w_frame;

  // Any malformed sequence drops the partial frame and waits for a fresh sop.
  always_comb begin
    w_write     = 1'b0;
    w_commit    = 1'b0;
    w_err       = 1'b0;
    w_idx       = r_count;
    w_count_nxt = r_count;
    if (i_src_valid) begin
      if (i_src_sop) begin
        w_idx = '0;
        if (i_src_eop) begin
          w_err       = 1'b1;
          w_count_nxt = '0;
        end else begin
          w_write     = 1'b1;
          w_count_nxt = SW'(1);
        end
      end else if (r_count == '0) begin
        w_err = 1'b1;
      end else if (i_src_eop) begin
        if (r_count == LAST) begin
          w_write  = 1'b1;
          w_commit = 1'b1;
        end else begin
          w_err = 1'b1;
        end
        w_count_nxt = '0;
      end else if (r_count == LAST) begin
        w_err       = 1'b1;
        w_count_nxt = '0;
      end else begin
        w_write     = 1'b1;
        w_count_nxt = r_count + SW'(1);
      end
    end
  end

  always_comb begin
    w_frame = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_frame[k*OUT_W +: OUT_W] = (w_write && (w_idx == SW'(k))) ? i_src_data : r_shadow[k];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_count     <= w_count_nxt;
      r_out_valid <= w_commit | i_byp_valid;
      if (w_write) begin
        r_shadow[w_idx] <= i_src_data;
      end
      if (i_byp_valid) begin
        r_out_data <= i_byp_frame;
      end else if (w_commit) begin
        r_out_data <= w_frame;
      end
    end
  end

  assign o_out_data  = r_out_data;
  assign o_out_valid = r_out_valid;
  assign o_ferr      = w_err;

endmodule

// File: rtl/fir_tdm_scheduler.sv
// Time-slot scheduler sharing one FIR between the channels of a PCM frame and
// reassembling its output. Optional macro FIR_BYPASS_EN adds bypass_i.
module fir_tdm_scheduler
  import fir_tdm_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int IN_W       = DEF_IN_W,
  parameter int OUT_W      = DEF_OUT_W,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
  input  logic                    AMCLK_i,
  input  logic                    nARST,
  input  logic [NUM_CH*IN_W-1:0]  in_data_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  output logic [IN_W-1:0]         fir_sink_data_o,
  output logic                    fir_sink_valid_o,
  output logic                    fir_sink_sop_o,
  output logic                    fir_sink_eop_o,
  input  logic                    fir_sink_ready_i,
  input  logic [OUT_W-1:0]        fir_src_data_i,
  input  logic                    fir_src_valid_i,
  input  logic                    fir_src_sop_i,
  input  logic                    fir_src_eop_i,
  output logic [NUM_CH*OUT_W-1:0] out_data_o,
  output logic                    out_valid_o,
`ifdef FIR_BYPASS_EN
  input  logic                    bypass_i,
`endif
  input  logic                    clr_status_i,
  output logic                    overrun_o,
  output logic                    framing_err_o,
  output logic [1:0]              dbg_state_o
);

  // Handshakes: a beat moves on a clock edge where valid and ready are both
  // high; valid never waits on ready, and a stalled beat holds all its fields.

  localparam int SW = slot_w(NUM_CH);
  localparam logic [SW-1:0] LAST_SLOT = SW'(NUM_CH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST =
    GAP_CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam issue_state_e POST_FRAME = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  issue_state_e            r_state;
  issue_state_e            w_next;
  logic [SW-1:0]           r_slot;
  logic [IN_W-1:0]         r_frame [NUM_CH];
  logic [GAP_CNT_W-1:0]    r_gap_cnt;
  logic                    r_alive;
  logic                    r_overrun;
  logic                    r_framing;

  logic                    w_ready;
  logic                    w_sink_valid;
  logic                    w_accept;
  logic                    w_xfer;
  logic                    w_byp_sel;
  logic                    w_byp_go;
  logic [NUM_CH*OUT_W-1:0] w_byp_frame;
  logic                    w_ferr_set;

  assign w_accept = in_valid_i & w_ready;
  assign w_xfer   = w_sink_valid & fir_sink_ready_i;

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_byp_sel ? POST_FRAME : ST_ISSUE;
      ST_ISSUE: if (w_xfer && (r_slot == LAST_SLOT)) w_next = POST_FRAME;
      ST_GAP:   if (r_gap_cnt == GAP_LAST) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // r_alive keeps in_ready_o low until the first edge after reset release.
  always_comb begin
    w_ready      = 1'b0;
    w_sink_valid = 1'b0;
    case (r_state)
      ST_IDLE:  w_ready      = r_alive;
      ST_ISSUE: w_sink_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      r_alive   <= 1'b0;
      r_slot    <= '0;
      r_gap_cnt <= '0;
      r_overrun <= 1'b0;
      r_framing <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_frame[k] <= '0;
      end
    end else begin
      r_alive <= 1'b1;
      if (w_accept) begin
        r_slot <= '0;
        for (int k = 0; k < NUM_CH; k++) begin
          r_frame[k] <= in_data_i[k*IN_W +: IN_W];
        end
      end else if (w_xfer) begin
        r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + SW'(1);
      end
      r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + GAP_CNT_W'(1) : '0;
      if (in_valid_i && !w_ready) begin
        r_overrun <= 1'b1;
      end else if (clr_status_i) begin
        r_overrun <= 1'b0;
      end
      if (w_ferr_set) begin
        r_framing <= 1'b1;
      end else if (clr_status_i) begin
        r_framing <= 1'b0;
      end
    end
  end

`ifdef FIR_BYPASS_EN
  logic r_byp_go;

  assign w_byp_sel = bypass_i;
  assign w_byp_go  = r_byp_go;

  always_ff @(posedge AMCLK_i or negedge nARST) begin
    if (!nARST) begin
      r_byp_go <= 1'b0;
    end else begin
      r_byp_go <= w_accept & bypass_i;
    end
  end

  // Sign-extend then shift left by OUT_W-IN_W: the sample lands in the MSBs.
  always_comb begin
    w_byp_frame = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_byp_frame[k*OUT_W +: OUT_W] = {r_frame[k], {(OUT_W-IN_W){1'b0}}};
    end
  end
`else
  assign w_byp_sel   = 1'b0;
  assign w_byp_go    = 1'b0;
  assign w_byp_frame = '0;
`endif

  fir_tdm_collector #(
    .NUM_CH (NUM_CH),
    .OUT_W  (OUT_W)
  ) u_collector (
    .i_clk       (AMCLK_i),
    .i_rst_n     (nARST),
    .i_src_data  (fir_src_data_i),
    .i_src_valid (fir_src_valid_i),
    .i_src_sop   (fir_src_sop_i),
    .i_src_eop   (fir_src_eop_i),
    .i_byp_valid (w_byp_go),
    .i_byp_frame (w_byp_frame),
    .o_out_data  (out_data_o),
    .o_out_valid (out_valid_o),
    .o_ferr      (w_ferr_set)
  );

  assign in_ready_o       = w_ready;
  assign fir_sink_valid_o = w_sink_valid;
  assign fir_sink_data_o  = w_sink_valid ? r_frame[r_slot] : '0;
  assign fir_sink_sop_o   = w_sink_valid && (r_slot == '0);
  assign fir_sink_eop_o   = w_sink_valid && (r_slot == LAST_SLOT);
  assign overrun_o        = r_overrun;
  assign framing_err_o    = r_framing;
  assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_fir_tdm_scheduler.sv
// Self-checking bench for fir_tdm_scheduler: directed steps from the test plan,
// then randomized traffic against a queue-based reference model.
module tb_fir_tdm_scheduler;

  localparam int NUM_CH     = 2;
  localparam int IN_W       = 16;
  localparam int OUT_W      = 24;
  localparam int GAP_CYCLES = 1;
  localparam int FW         = NUM_CH * OUT_W;

  // ---------------- clock / reset / DUT ----------------
  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NUM_CH*IN_W-1:0] in_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [IN_W-1:0]        sink_data;
  logic                   sink_valid, sink_sop, sink_eop;
  logic                   sink_ready = 1'b1;
  logic [OUT_W-1:0]       src_data = '0;
  logic                   src_valid = 1'b0, src_sop = 1'b0, src_eop = 1'b0;
  logic [FW-1:0]          out_data;
  logic                   out_valid;
  logic                   clr = 1'b0;
  logic                   bypass = 1'b0;
  logic                   overrun, framing_err;
  logic [1:0]             dbg_state;

  always #5 clk = ~clk;

  fir_tdm_scheduler #(
    .NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .AMCLK_i          (clk),
    .nARST            (rst_n),
    .in_data_i        (in_data),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .fir_sink_data_o  (sink_data),
    .fir_sink_valid_o (sink_valid),
    .fir_sink_sop_o   (sink_sop),
    .fir_sink_eop_o   (sink_eop),
    .fir_sink_ready_i (sink_ready),
    .fir_src_data_i   (src_data),
    .fir_src_valid_i  (src_valid),
    .fir_src_sop_i    (src_sop),
    .fir_src_eop_i    (src_eop),
    .out_data_o       (out_data),
    .out_valid_o      (out_valid),
`ifdef FIR_BYPASS_EN
    .bypass_i         (bypass),
`endif
    .clr_status_i     (clr),
    .overrun_o        (overrun),
    .framing_err_o    (framing_err),
    .dbg_state_o      (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [IN_W+1:0]  exp_q[$];   // {sop, eop, sample} expected on the FIR sink
  logic [FW-1:0]    out_q[$];   // frames expected on out_data_o
  logic [OUT_W+1:0] src_q[$];   // FIR result beats waiting to be driven
  logic [FW-1:0]    exp_out = '0;
  logic [IN_W+1:0]  prev_beat = '0;
  logic [IN_W+1:0]  beat;
  bit               prev_stall = 1'b0;
  bit               alive_m = 1'b0;
  bit               exp_ovr = 1'b0;
  bit               exp_ferr = 1'b0;
  bit               m_rdy;
  int               cool = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is accepted only when nothing is queued for the
  // sink and the post-frame gap has elapsed; accepted frames become NUM_CH beats.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      cool       = 0;
      alive_m    = 1'b0;
      exp_ovr    = 1'b0;
      prev_stall = 1'b0;
      exp_out    = '0;
    end else begin
      m_rdy = alive_m && (exp_q.size() == 0) && (cool == 0);
      chk("in_ready", 64'(in_ready), 64'(m_rdy));
      chk("overrun", 64'(overrun), 64'(exp_ovr));
      chk("framing_err", 64'(framing_err), 64'(exp_ferr));
      if (prev_stall)
        chk("sink_hold", 64'({sink_valid, sink_sop, sink_eop, sink_data}), 64'({1'b1, prev_beat}));
      if (sink_valid && sink_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL sink_extra observed=%0h expected=none", sink_data);
        end else begin
          beat = exp_q.pop_front();
          chk("sink_beat", 64'({sink_sop, sink_eop, sink_data}), 64'(beat));
          if (beat[IN_W]) cool = GAP_CYCLES;
        end
      end else if (cool > 0) begin
        cool--;
      end
      prev_stall = sink_valid && !sink_ready;
      prev_beat  = {sink_sop, sink_eop, sink_data};
      if (in_valid && m_rdy) begin
        for (int k = 0; k < NUM_CH; k++)
          exp_q.push_back({(k == 0), (k == NUM_CH - 1), in_data[k*IN_W +: IN_W]});
      end
      if (in_valid && !m_rdy) exp_ovr = 1'b1;
      else if (clr) exp_ovr = 1'b0;
      if (out_valid) begin
        if (out_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL out_extra observed=%0h expected=none", out_data);
        end else begin
          exp_out = out_q.pop_front();
        end
      end
      chk("out_data", 64'(out_data), 64'(exp_out));
      alive_m = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_frame(input logic [NUM_CH*IN_W-1:0] f);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic fir_beat(input logic [OUT_W-1:0] d, input bit sop, input bit eop);
    @(posedge clk); #1;
    src_valid = 1'b1;
    src_data  = d;
    src_sop   = sop;
    src_eop   = eop;
  endtask

  task automatic fir_idle();
    @(posedge clk); #1;
    src_valid = 1'b0;
    src_sop   = 1'b0;
    src_eop   = 1'b0;
  endtask

  task automatic clear_status();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr      = 1'b0;
    exp_ferr = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_sink_valid"}, 64'(sink_valid), 64'd0);
    chk({tag, "_sink_sop"}, 64'(sink_sop), 64'd0);
    chk({tag, "_sink_eop"}, 64'(sink_eop), 64'd0);
    chk({tag, "_sink_data"}, 64'(sink_data), 64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_out_data"}, 64'(out_data), 64'd0);
    chk({tag, "_overrun"}, 64'(overrun), 64'd0);
    chk({tag, "_framing"}, 64'(framing_err), 64'd0);
  endtask

  // ---------------- directed + random steps ----------------
  logic [FW-1:0]    f_out;
  logic [FW-1:0]    held;
  logic [OUT_W+1:0] sb;

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_release_ready", 64'(in_ready), 64'd1);

    // basic frame: L then R on consecutive cycles, ready again 4 cycles later
    drive_frame({16'hABCD, 16'h1234});
    @(negedge clk);
    chk("t1_slot0", 64'({sink_valid, sink_sop, sink_eop, sink_data}), 64'({3'b110, 16'h1234}));
    @(negedge clk);
    chk("t1_slot1", 64'({sink_valid, sink_sop, sink_eop, sink_data}), 64'({3'b101, 16'hABCD}));
    @(negedge clk);
    chk("t1_gap_busy", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("t1_ready_back", 64'(in_ready), 64'd1);

    // back-pressure on slot 1 for 3 cycles
    repeat (2) @(posedge clk);
    drive_frame({16'hABCD, 16'h1234});
    @(posedge clk); #1;
    sink_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t2_held", 64'({sink_valid, sink_eop, sink_data}), 64'({2'b11, 16'hABCD}));
    @(posedge clk); #1;
    sink_ready = 1'b1;
    repeat (4) @(posedge clk);

    // overrun: second offer one cycle after acceptance is dropped
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data  = {16'h2222, 16'h1111};
    @(posedge clk); #1;
    in_data  = {16'h4444, 16'h3333};
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t3_overrun_set", 64'(overrun), 64'd1);
    repeat (5) @(posedge clk);
    clear_status();
    @(negedge clk);
    chk("t3_overrun_clr", 64'(overrun), 64'd0);

    // well-formed FIR result frame
    out_q.push_back({24'hFFFF00, 24'h000100});
    fir_beat(24'h000100, 1'b1, 1'b0);
    fir_beat(24'hFFFF00, 1'b0, 1'b1);
    fir_idle();
    @(negedge clk);
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    chk("t4_out_data", 64'(out_data), 64'({24'hFFFF00, 24'h000100}));
    @(negedge clk);
    chk("t4_strobe_one", 64'(out_valid), 64'd0);

    // eop without sop: flagged, nothing committed, next good frame commits
    held = out_data;
    fir_beat(24'h123456, 1'b0, 1'b1);
    fir_idle();
    exp_ferr = 1'b1;
    @(negedge clk);
    chk("t5_ferr", 64'(framing_err), 64'd1);
    chk("t5_no_commit", 64'({out_valid, out_data}), 64'({1'b0, held}));
    out_q.push_back({24'h00ABCD, 24'h7FFF00});
    fir_beat(24'h7FFF00, 1'b1, 1'b0);
    fir_beat(24'h00ABCD, 1'b0, 1'b1);
    fir_idle();
    @(negedge clk);
    chk("t5_recover", 64'({out_valid, out_data}), 64'({1'b1, 24'h00ABCD, 24'h7FFF00}));
    clear_status();

    // asynchronous reset in the middle of ISSUE
    sink_ready = 1'b0;
    drive_frame({16'h5A5A, 16'hA5A5});
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_mid");
    exp_ferr = 1'b0;
    out_q.delete();
    repeat (2) @(posedge clk); #1;
    sink_ready = 1'b1;
    rst_n      = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("t6_ready", 64'(in_ready), 64'd1);
    drive_frame({16'hBEEF, 16'hCAFE});
    @(negedge clk);
    chk("t6_restart", 64'({sink_valid, sink_sop, sink_data}), 64'({2'b11, 16'hCAFE}));
    repeat (4) @(posedge clk);

    // randomized traffic on both sides
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid   = ($urandom_range(0, 4) == 0);
      in_data    = $urandom;
      sink_ready = ($urandom_range(0, 3) != 0);
      clr        = ($urandom_range(0, 40) == 0);
      if (src_q.size() == 0 && $urandom_range(0, 5) == 0) begin
        for (int k = 0; k < NUM_CH; k++) begin
          f_out[k*OUT_W +: OUT_W] = OUT_W'($urandom);
          src_q.push_back({(k == 0), (k == NUM_CH - 1), f_out[k*OUT_W +: OUT_W]});
        end
        out_q.push_back(f_out);
      end
      if (src_q.size() > 0 && $urandom_range(0, 2) != 0) begin
        sb = src_q.pop_front();
        {src_sop, src_eop, src_data} = sb;
        src_valid = 1'b1;
      end else begin
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
      end
    end

    // drain
    in_valid   = 1'b0;
    clr        = 1'b0;
    sink_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (src_q.size() > 0) begin
        sb = src_q.pop_front();
        {src_sop, src_eop, src_data} = sb;
        src_valid = 1'b1;
      end else begin
        src_valid = 1'b0;
        src_sop   = 1'b0;
        src_eop   = 1'b0;
      end
    end
    @(negedge clk);
    chk("drain_sink_q", 64'(exp_q.size()), 64'd0);
    chk("drain_out_q", 64'(out_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
